jt51_noise_ctrl: RTL and testbench

Sequencer for the JT51 noise path. It owns the noise-enable (NE) and noise-frequency (NFRQ) register state and divides the 32-slot frame rate down to the programmed noise rate. It drives the `base` strobe of the external 17-bit noise LFSR, captures the LFSR output bit after each shift and presents it as a signed noise amplitude to the operator-32 output mux. It sits between the register interface and the noise LFSR instance.

---
 rtl/jt51_noise_ctrl.sv | 101 ++++++++++
 tb/tb_jt51_noise_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_noise_ctrl.sv
// Noise-path sequencer: stages NE/NFRQ to the frame boundary, divides the frame
// rate down to the noise rate, strobes the LFSR and captures its output bit.
module jt51_noise_ctrl #(
   parameter int AMP_W = 11
) (
   input  logic                    rst,
   input  logic                    clk,
   input  logic                    cen,
   input  logic                    zero,
   input  logic                    wr_noise,
   input  logic                    din_ne,
   input  logic [4:0]              din_nfrq,
   input  logic                    lfsr_out,
   output logic                    base,
   output logic                    noise_bit,
   output logic signed [AMP_W-1:0] noise_amp,
   output logic                    ne_act,
   output logic [4:0]              nfrq_act
);

   localparam logic signed [AMP_W-1:0] AMP_POS = {1'b0, {(AMP_W-1){1'b1}}};
   localparam logic signed [AMP_W-1:0] AMP_NEG = {1'b1, {(AMP_W-1){1'b0}}};

   logic       pend;
   logic       pend_ne;
   logic [4:0] pend_nfrq;
   logic [4:0] cnt;
   logic       cap;

   logic       bnd;
   logic       new_ne;
   logic [4:0] new_nfrq;
   logic [4:0] term;
   logic [5:0] inc;
   logic       fire;

   // A write landing on the boundary bypasses the staging registers.
   always_comb begin
      bnd      = cen & zero;
      new_ne   = ne_act;
      new_nfrq = nfrq_act;
      if (wr_noise) begin
         new_ne   = din_ne;
         new_nfrq = din_nfrq;
      end else if (pend) begin
         new_ne   = pend_ne;
         new_nfrq = pend_nfrq;
      end
      term = 5'd31 - new_nfrq;
      inc  = {1'b0, cnt} + 6'd1;
      fire = bnd & new_ne & (inc > {1'b0, term});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         pend_ne   <= 1'b0;
         pend_nfrq <= 5'd0;
         cnt       <= 5'd0;
         cap       <= 1'b0;
         base      <= 1'b0;
         noise_bit <= 1'b0;
         noise_amp <= '0;
         ne_act    <= 1'b0;
         nfrq_act  <= 5'd0;
      end else begin
         if (wr_noise) begin
            pend_ne   <= din_ne;
            pend_nfrq <= din_nfrq;
         end
         if (bnd)
            pend <= 1'b0;
         else if (wr_noise)
            pend <= 1'b1;

         if (cen) begin
            if (bnd) begin
               ne_act   <= new_ne;
               nfrq_act <= new_nfrq;
            end
            if (bnd && !new_ne) begin
               cnt       <= 5'd0;
               base      <= 1'b0;
               cap       <= 1'b0;
               noise_amp <= '0;
            end else begin
               if (bnd)
                  cnt <= fire ? 5'd0 : inc[4:0];
               // base lasts exactly one cen period; the LFSR shifts on its last cen
               base <= fire;
               cap  <= base;
               if (cap) begin
                  noise_bit <= lfsr_out;
                  noise_amp <= lfsr_out ? AMP_POS : AMP_NEG;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jt51_noise_ctrl.sv
// Bench for jt51_noise_ctrl: period-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_jt51_noise_ctrl;
   localparam int AMP_W = 11;

   logic                    rst, clk, cen, zero, wr_noise, din_ne, lfsr_out;
   logic [4:0]              din_nfrq;
   logic                    base, noise_bit, ne_act;
   logic signed [AMP_W-1:0] noise_amp;
   logic [4:0]              nfrq_act;

   int checks = 0;
   int passes = 0;

   jt51_noise_ctrl #(.AMP_W(AMP_W)) dut (
      .rst(rst), .clk(clk), .cen(cen), .zero(zero), .wr_noise(wr_noise),
      .din_ne(din_ne), .din_nfrq(din_nfrq), .lfsr_out(lfsr_out),
      .base(base), .noise_bit(noise_bit), .noise_amp(noise_amp),
      .ne_act(ne_act), .nfrq_act(nfrq_act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external LFSR, shifted only when the DUT requests it
   logic [16:0] lfsr = 17'h12345;
   int          shifts = 0;
   always @(posedge clk) begin
      if (cen && base) begin
         lfsr   <= {lfsr[15:0], ~(lfsr[16] ^ lfsr[13])};
         shifts <= shifts + 1;
      end
   end
   assign lfsr_out = lfsr[16];

   // cen every other clk, zero on every 32nd cen
   bit ph;
   int slot;
   initial begin
      cen = 1'b0; zero = 1'b0; ph = 1'b0; slot = 0;
      forever begin
         @(posedge clk);
         #1;
         ph   = ~ph;
         cen  = ph;
         zero = ph && (slot == 0);
         if (ph) slot = (slot + 1) % 32;
      end
   end

   // reference model: frames since the last fire, and cen steps since the fire
   bit       m_ne, m_pend, m_pne, m_bit, m_bnd, m_nne;
   bit [4:0] m_nfrq, m_pnfrq, m_nnf;
   int       m_frames, m_phase, m_old, m_amp;
   always @(posedge clk) begin
      if (rst) begin
         m_ne = 0; m_nfrq = 0; m_pend = 0; m_pne = 0; m_pnfrq = 0;
         m_frames = 0; m_phase = 0; m_bit = 0; m_amp = 0;
      end else begin
         m_bnd = cen && zero;
         if (m_bnd) begin
            m_nne = m_ne; m_nnf = m_nfrq;
            if (wr_noise) begin
               m_nne = din_ne; m_nnf = din_nfrq;
            end else if (m_pend) begin
               m_nne = m_pne; m_nnf = m_pnfrq;
            end
            m_ne = m_nne; m_nfrq = m_nnf; m_pend = 0;
         end else if (wr_noise) begin
            m_pend = 1; m_pne = din_ne; m_pnfrq = din_nfrq;
         end
         if (cen) begin
            if (m_bnd && !m_ne) begin
               m_phase = 0; m_amp = 0; m_frames = 0;
            end else begin
               m_old   = m_phase;
               m_phase = 0;
               if (m_old == 2) begin
                  m_bit = lfsr[16];
                  m_amp = m_bit ? 1023 : -1024;
               end
               if (m_old == 1) m_phase = 2;
               if (m_bnd) begin
                  if (m_frames + 1 >= 32 - int'(m_nfrq)) begin
                     m_frames = 0; m_phase = 1;
                  end else begin
                     m_frames++;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (base === (m_phase == 1) && noise_bit === m_bit && int'(noise_amp) == m_amp &&
          ne_act === m_ne && nfrq_act === m_nfrq)
         passes++;
      else
         $display("FAIL model t=%0t got base=%0b bit=%0b amp=%0d ne=%0b nfrq=%0d want base=%0b bit=%0b amp=%0d ne=%0b nfrq=%0d",
                  $time, base, noise_bit, noise_amp, ne_act, nfrq_act,
                  (m_phase == 1), m_bit, m_amp, m_ne, m_nfrq);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // leaves the bench positioned so the next edge is a frame boundary
   task automatic to_bnd();
      int n = 0;
      tick();
      while (!(cen && zero) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("boundary_timeout", 0, 1);
   endtask

   task automatic pass_bnd(input int k);
      repeat (k) begin
         to_bnd();
         tick();
      end
   endtask

   task automatic write(input bit ne, input bit [4:0] nfrq);
      wr_noise = 1'b1; din_ne = ne; din_nfrq = nfrq;
      tick();
      wr_noise = 1'b0;
   endtask

   task automatic restart(input bit [4:0] nfrq);
      write(1'b0, nfrq);
      to_bnd(); tick();
      write(1'b1, nfrq);
      to_bnd(); tick();
   endtask

   int s0;

   initial begin
      rst = 1'b1; wr_noise = 1'b0; din_ne = 1'b0; din_nfrq = 5'd0;
      repeat (3) tick();
      chk("rst_base", base, 0);
      chk("rst_bit", noise_bit, 0);
      chk("rst_amp", noise_amp, 0);
      chk("rst_ne", ne_act, 0);
      chk("rst_nfrq", nfrq_act, 0);
      rst = 1'b0;

      // NFRQ=31: one fire per frame
      to_bnd(); tick(); tick();
      write(1'b1, 5'd31);
      chk("staged_ne_hold", ne_act, 0);
      to_bnd(); tick();
      chk("nfrq31_ne_act", ne_act, 1);
      chk("nfrq31_first_fire", base, 1);
      s0 = shifts;
      pass_bnd(8); tick(); tick();
      chk("nfrq31_shifts", shifts - s0, 9);
      tick(); tick();
      chk("nfrq31_amp_range", int'(noise_amp == 1023 || noise_amp == -1024), 1);
      chk("nfrq31_bit_tracks", noise_bit, lfsr[16]);

      // pulse counts over 128 frames
      restart(5'd0);
      s0 = shifts;
      pass_bnd(128); tick(); tick();
      chk("nfrq0_pulses", shifts - s0, 4);
      restart(5'd28);
      s0 = shifts;
      pass_bnd(128); tick(); tick();
      chk("nfrq28_pulses", shifts - s0, 32);

      // lowering NFRQ mid-period below the current count fires at once
      restart(5'd0);
      pass_bnd(19);
      write(1'b1, 5'd20);
      to_bnd(); tick();
      chk("mid_fire", base, 1);
      pass_bnd(11);
      chk("mid_nofire_11", base, 0);
      pass_bnd(1);
      chk("mid_fire_12", base, 1);

      // write coincident with the boundary, then two writes in one frame
      write(1'b0, 5'd31);
      to_bnd(); tick();
      to_bnd();
      wr_noise = 1'b1; din_ne = 1'b1; din_nfrq = 5'd31;
      tick();
      wr_noise = 1'b0;
      chk("bnd_wr_ne", ne_act, 1);
      chk("bnd_wr_nfrq", nfrq_act, 31);
      chk("bnd_wr_fire", base, 1);
      write(1'b1, 5'd5);
      write(1'b1, 5'd9);
      chk("two_wr_hold", nfrq_act, 31);
      to_bnd(); tick();
      chk("two_wr_last_wins", nfrq_act, 9);

      // NE=0 written while a capture is pending
      write(1'b1, 5'd31);
      to_bnd(); tick();
      chk("ne0_pre_fire", base, 1);
      tick(); tick();
      write(1'b0, 5'd31);
      to_bnd(); tick();
      chk("ne0_amp", noise_amp, 0);
      chk("ne0_base", base, 0);
      s0 = shifts;
      pass_bnd(5);
      chk("ne0_no_shifts", shifts - s0, 0);
      chk("ne0_bit_frozen", noise_bit, lfsr[16]);
      chk("ne0_amp_held", noise_amp, 0);
      write(1'b1, 5'd29);
      to_bnd(); tick();
      chk("reen_b1", base, 0);
      pass_bnd(1);
      chk("reen_b2", base, 0);
      pass_bnd(1);
      chk("reen_b3_fire", base, 1);

      // reset between fire and capture
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_base", base, 0);
      chk("rstmid_ne", ne_act, 0);
      chk("rstmid_nfrq", nfrq_act, 0);
      chk("rstmid_amp", noise_amp, 0);
      chk("rstmid_bit", noise_bit, 0);
      s0 = shifts;
      repeat (10) tick();
      chk("rstmid_no_shift", shifts - s0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
